// File: rtl/lable_to_pix_if.sv
// lable_to_pix_if: scan-request / pixel-response bundle between scan generator and label renderer.
`default_nettype none

interface lable_to_pix_if #(
  parameter int IDX_W   = 3,
  parameter int PIX_X_W = 12,
  parameter int PIX_Y_W = 12
);
  logic               sof_i;
  logic [IDX_W-1:0]   lable_idx_i;
  logic               blink_i;
  logic               valid_i;
  logic [PIX_X_W-1:0] pos_x_i;
  logic [PIX_Y_W-1:0] pos_y_i;
  logic               pix_valid_o;
  logic               pix_o;

  modport master (
    output sof_i, lable_idx_i, blink_i, valid_i, pos_x_i, pos_y_i,
    input  pix_valid_o, pix_o
  );

  modport slave (
    input  sof_i, lable_idx_i, blink_i, valid_i, pos_x_i, pos_y_i,
    output pix_valid_o, pix_o
  );
endinterface

`default_nettype wire

// File: rtl/lable_to_pix_pipe.sv
// lable_to_pix_pipe: 2-cycle label glyph renderer, frame-synchronous label index, ROM image in rom_bit().
// Rev 1.0 -- optional blink gating under macro LABLE_BLINK_EN.
`default_nettype none

module lable_to_pix_pipe #(
  parameter int LABLE_CNT    = 7,
  parameter int PIX_X_W      = 12,
  parameter int PIX_Y_W      = 12,
  parameter int LABLE_W      = 130,
  parameter int LABLE_H      = 30,
  parameter int L_OFFSET     = 1,
  parameter int T_OFFSET     = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  lable_to_pix_if.slave bus
);
  localparam int IDX_W     = $clog2(LABLE_CNT);
  localparam int ADDR_W    = $clog2(LABLE_CNT * LABLE_W * LABLE_H);
  localparam int FRAME_PIX = LABLE_W * LABLE_H;

  localparam logic [PIX_X_W:0]  X_LO     = (PIX_X_W+1)'(L_OFFSET);
  localparam logic [PIX_X_W:0]  X_HI     = (PIX_X_W+1)'(L_OFFSET + LABLE_W);
  localparam logic [PIX_Y_W:0]  Y_LO     = (PIX_Y_W+1)'(T_OFFSET);
  localparam logic [PIX_Y_W:0]  Y_HI     = (PIX_Y_W+1)'(T_OFFSET + LABLE_H);
  localparam logic [ADDR_W-1:0] ROM_MASK = ADDR_W'(32'h0000_5225);

  // Glyph image: each ROM bit is the parity of a fixed subset of its address bits.
  function automatic logic rom_bit(input logic [ADDR_W-1:0] a);
    return ^(a & ROM_MASK);
  endfunction

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              blank_q, blank_d;
  logic [PIX_X_W:0]  w_x;
  logic [PIX_Y_W:0]  w_y;
  logic              w_in_box;
  logic              w_vis;
  logic              w_gate;
  logic [ADDR_W-1:0] w_dx, w_dy, w_addr;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              v1_q, vis1_q;
  logic              pix_valid_q, pix_q;
  logic              w_rom_bit;

  // A request in the sof_i cycle already belongs to the new frame, so it sees the _d values.
  always_comb begin
    idx_d   = idx_q;
    blank_d = blank_q;
    if (bus.sof_i) begin
      idx_d   = bus.lable_idx_i;
      blank_d = (32'(bus.lable_idx_i) >= LABLE_CNT);
    end
  end

  always_comb begin
    w_x      = {1'b0, bus.pos_x_i};
    w_y      = {1'b0, bus.pos_y_i};
    w_in_box = (w_x >= X_LO) && (w_x < X_HI) && (w_y >= Y_LO) && (w_y < Y_HI);
    w_dx     = ADDR_W'(w_x - X_LO);
    w_dy     = ADDR_W'(w_y - Y_LO);
    w_addr   = '0;
    if (w_in_box) begin
      w_addr = ADDR_W'(idx_d) * ADDR_W'(FRAME_PIX) + w_dy * ADDR_W'(LABLE_W) + w_dx;
    end
    w_vis = w_in_box & ~blank_d & w_gate;
  end

`ifdef LABLE_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    frm_cnt_d = frm_cnt_q;
    phase_d   = phase_q;
    if (bus.sof_i) begin
      if (frm_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frm_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        frm_cnt_d = frm_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frm_cnt_q <= '0;
      phase_q   <= 1'b1;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign w_gate = ~(bus.blink_i & ~phase_d);
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = bus.blink_i;
  assign w_gate       = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q       <= '0;
      blank_q     <= 1'b0;
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      vis1_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      blank_q     <= blank_d;
      rom_addr_q  <= w_addr;
      v1_q        <= bus.valid_i;
      vis1_q      <= w_vis;
      pix_valid_q <= v1_q;
      pix_q       <= v1_q & vis1_q & w_rom_bit;
    end
  end

  assign w_rom_bit       = rom_bit(rom_addr_q);
  assign bus.pix_valid_o = pix_valid_q;
  assign bus.pix_o       = pix_q;

endmodule

`default_nettype wire
